// File: rtl/scalar_mult_ctrl_pkg.sv
// Shared definitions for the k*P double-and-add sequencer.
package scalar_mult_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_DBL  = 3'd2,
      S_ADD  = 3'd3,
      S_FIN  = 3'd4
   } state_t;

   localparam logic OP_DBL = 1'b0;
   localparam logic OP_ADD = 1'b1;

   // Projective point at infinity (1 : 0 : 0)
   localparam int unsigned INF_X = 1;
   localparam int unsigned INF_Y = 0;
   localparam int unsigned INF_Z = 0;

   function automatic int unsigned idx_width(input int unsigned w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/scalar_mult_ctrl_msb_index.sv
// Priority encoder: position of the highest set bit of the scalar plus a nonzero flag.
module scalar_mult_ctrl_msb_index
   import scalar_mult_ctrl_pkg::*;
#(
   parameter int unsigned K_W   = 4,
   parameter int unsigned IDX_W = idx_width(K_W)
) (
   input  logic [K_W-1:0]   i_k,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_nz
);

   always_comb begin
      o_idx = '0;
      o_nz  = 1'b0;
      for (int i = 0; i < K_W; i++) begin
         if (i_k[i]) begin
            o_idx = IDX_W'(i);
            o_nz  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/scalar_mult_ctrl.sv
// Left-to-right double-and-add sequencer driving an external point unit over req/ack.
// Keeps the running point Q and presents k*P on done.
module scalar_mult_ctrl
   import scalar_mult_ctrl_pkg::*;
#(
   parameter int unsigned N   = 3,
   parameter int unsigned K_W = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [K_W-1:0] k,
   input  logic [N-1:0]   X_in,
   input  logic [N-1:0]   Y_in,
   input  logic [N-1:0]   Z_in,
   output logic           busy,
   output logic           done,
   output logic [N-1:0]   X_out,
   output logic [N-1:0]   Y_out,
   output logic [N-1:0]   Z_out,
   output logic           op_req,
   output logic           op_sel,
   output logic [N-1:0]   op_AX,
   output logic [N-1:0]   op_AY,
   output logic [N-1:0]   op_AZ,
   output logic [N-1:0]   op_BX,
   output logic [N-1:0]   op_BY,
   output logic [N-1:0]   op_BZ,
   input  logic           op_ack,
   input  logic [N-1:0]   op_RX,
   input  logic [N-1:0]   op_RY,
   input  logic [N-1:0]   op_RZ
);

   localparam int unsigned IDX_W = idx_width(K_W);

   state_t             r_state;
   logic [K_W-1:0]     r_k;
   logic [N-1:0]       r_px, r_py, r_pz;
   logic [N-1:0]       r_qx, r_qy, r_qz;
   logic [IDX_W-1:0]   r_idx;
   logic               r_busy, r_done;
   logic [N-1:0]       r_xo, r_yo, r_zo;
   logic               r_op_req, r_op_sel;
   logic [N-1:0]       r_ax, r_ay, r_az;
   logic [N-1:0]       r_bx, r_by, r_bz;

   logic [IDX_W-1:0]   w_msb;
   logic               w_nz;

   scalar_mult_ctrl_msb_index #(
      .K_W   (K_W),
      .IDX_W (IDX_W)
   ) u_msb_index (
      .i_k   (r_k),
      .o_idx (w_msb),
      .o_nz  (w_nz)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_k      <= '0;
         r_px     <= '0;
         r_py     <= '0;
         r_pz     <= '0;
         r_qx     <= N'(INF_X);
         r_qy     <= N'(INF_Y);
         r_qz     <= N'(INF_Z);
         r_idx    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_xo     <= N'(INF_X);
         r_yo     <= N'(INF_Y);
         r_zo     <= N'(INF_Z);
         r_op_req <= 1'b0;
         r_op_sel <= OP_DBL;
         r_ax     <= '0;
         r_ay     <= '0;
         r_az     <= '0;
         r_bx     <= '0;
         r_by     <= '0;
         r_bz     <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_k     <= k;
                  r_px    <= X_in;
                  r_py    <= Y_in;
                  r_pz    <= Z_in;
                  r_busy  <= 1'b1;
                  r_state <= S_LOAD;
               end
            end

            S_LOAD: begin
               if (!w_nz) begin
                  r_qx    <= N'(INF_X);
                  r_qy    <= N'(INF_Y);
                  r_qz    <= N'(INF_Z);
                  r_state <= S_FIN;
               end else begin
                  r_qx <= r_px;
                  r_qy <= r_py;
                  r_qz <= r_pz;
                  if (w_msb == '0) begin
                     r_state <= S_FIN;
                  end else begin
                     r_idx   <= w_msb - IDX_W'(1);
                     r_state <= S_DBL;
                  end
               end
            end

            // First cycle in an op state is the idle gap; request is raised at its end
            S_DBL, S_ADD: begin
               if (!r_op_req) begin
                  r_op_req <= 1'b1;
                  r_op_sel <= (r_state == S_ADD) ? OP_ADD : OP_DBL;
                  r_ax     <= r_qx;
                  r_ay     <= r_qy;
                  r_az     <= r_qz;
                  r_bx     <= r_px;
                  r_by     <= r_py;
                  r_bz     <= r_pz;
               end else if (op_ack) begin
                  r_op_req <= 1'b0;
                  r_qx     <= op_RX;
                  r_qy     <= op_RY;
                  r_qz     <= op_RZ;
                  if (r_state == S_DBL && r_k[r_idx]) begin
                     r_state <= S_ADD;
                  end else if (r_idx == '0) begin
                     r_state <= S_FIN;
                  end else begin
                     r_idx   <= r_idx - IDX_W'(1);
                     r_state <= S_DBL;
                  end
               end
            end

            S_FIN: begin
               r_xo    <= r_qx;
               r_yo    <= r_qy;
               r_zo    <= r_qz;
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign X_out  = r_xo;
   assign Y_out  = r_yo;
   assign Z_out  = r_zo;
   assign op_req = r_op_req;
   assign op_sel = r_op_sel;
   assign op_AX  = r_ax;
   assign op_AY  = r_ay;
   assign op_AZ  = r_az;
   assign op_BX  = r_bx;
   assign op_BY  = r_by;
   assign op_BZ  = r_bz;

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// Bench for scalar_mult_ctrl: point-unit model treating X as an integer multiple of P.
module tb_scalar_mult_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [3:0] k = '0;
   logic [7:0] X_in = '0, Y_in = '0, Z_in = '0;
   logic       busy, done, op_req, op_sel;
   logic [7:0] X_out, Y_out, Z_out;
   logic [7:0] op_AX, op_AY, op_AZ, op_BX, op_BY, op_BZ;
   logic       op_ack = 1'b0;
   logic [7:0] op_RX = '0, op_RY = '0, op_RZ = '0;

   int n_asrt = 0;
   int n_fail = 0;

   int L_cyc   = 0;
   bit unit_en = 1'b0;
   bit stray   = 1'b0;
   int cnt     = 0;
   bit sel_q[$];

   always #5 clk = ~clk;

   scalar_mult_ctrl #(.N(8), .K_W(4)) dut (
      .clk(clk), .reset(reset), .start(start), .k(k),
      .X_in(X_in), .Y_in(Y_in), .Z_in(Z_in),
      .busy(busy), .done(done),
      .X_out(X_out), .Y_out(Y_out), .Z_out(Z_out),
      .op_req(op_req), .op_sel(op_sel),
      .op_AX(op_AX), .op_AY(op_AY), .op_AZ(op_AZ),
      .op_BX(op_BX), .op_BY(op_BY), .op_BZ(op_BZ),
      .op_ack(op_ack), .op_RX(op_RX), .op_RY(op_RY), .op_RZ(op_RZ)
   );

   // Point unit model: acks after L_cyc wait cycles; dbl X->2X, add X->AX+BX
   always @(negedge clk) begin
      if (unit_en && op_req === 1'b1 && !reset) begin
         if (cnt == L_cyc) begin
            op_ack = 1'b1;
            op_RX  = op_sel ? 8'(op_AX + op_BX) : 8'(op_AX << 1);
            op_RY  = op_AY;
            op_RZ  = op_AZ;
            sel_q.push_back(op_sel);
            cnt = 0;
         end else begin
            op_ack = 1'b0;
            cnt++;
         end
      end else begin
         op_ack = stray;
         if (stray) op_RX = 8'hEE;
         cnt = 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_run(input logic [3:0] kk, input logic [7:0] px, input logic [7:0] py,
                         input logic [7:0] pz, input int lat, input bit poke, input string tag);
      int m, nops, cyc, exp_lat;
      logic [7:0] ex, ey, ez;
      bit eq[$];
      bit seen;
      // Reference: Q = k*P as integer multiple, op list from scalar bits below the MSB
      m = -1;
      for (int i = 0; i < 4; i++) if (kk[i]) m = i;
      eq.delete();
      for (int i = m - 1; i >= 0; i--) begin
         eq.push_back(1'b0);
         if (kk[i]) eq.push_back(1'b1);
      end
      nops    = eq.size();
      exp_lat = 3 + nops * (lat + 2);
      if (kk == 0) begin
         ex = 8'd1; ey = 8'd0; ez = 8'd0;
      end else begin
         ex = 8'(kk * px); ey = py; ez = pz;
      end
      L_cyc = lat;
      unit_en = 1'b1;
      sel_q.delete();
      @(negedge clk);
      start = 1'b1; k = kk; X_in = px; Y_in = py; Z_in = pz;
      cyc = 0;
      seen = 1'b0;
      while (!seen && cyc < 400) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (cyc == 1) begin
            start = 1'b0;
            check({tag, "_busy_on"}, 32'(busy), 32'd1);
         end
         if (poke && cyc == 4) begin
            start = 1'b1; k = 4'd2; X_in = 8'd99;
         end
         if (poke && cyc == 5) start = 1'b0;
         if (done === 1'b1) seen = 1'b1;
      end
      check({tag, "_done_seen"}, 32'(seen), 32'd1);
      check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
      check({tag, "_X"}, 32'(X_out), 32'(ex));
      check({tag, "_Y"}, 32'(Y_out), 32'(ey));
      check({tag, "_Z"}, 32'(Z_out), 32'(ez));
      check({tag, "_busy_off"}, 32'(busy), 32'd0);
      check({tag, "_nops"}, 32'(sel_q.size()), 32'(nops));
      for (int i = 0; i < nops && i < sel_q.size(); i++)
         check({tag, "_opsel"}, 32'(sel_q[i]), 32'(eq[i]));
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_X_hold"}, 32'(X_out), 32'(ex));
   endtask

   initial begin
      bit found, bad_done, bad_req;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_op_req", 32'(op_req), 32'd0);
      check("rst_op_sel", 32'(op_sel), 32'd0);
      check("rst_X", 32'(X_out), 32'd1);
      check("rst_Y", 32'(Y_out), 32'd0);
      check("rst_Z", 32'(Z_out), 32'd0);
      check("rst_AX", 32'(op_AX), 32'd0);

      do_run(4'd0,  8'd1, 8'd1, 8'd1, 0, 1'b0, "k0");
      do_run(4'd1,  8'd1, 8'd5, 8'd1, 0, 1'b0, "k1");
      do_run(4'd11, 8'd1, 8'd2, 8'd3, 0, 1'b0, "k11_L0");
      do_run(4'd11, 8'd1, 8'd2, 8'd3, 3, 1'b0, "k11_L3");
      do_run(4'd11, 8'd1, 8'd2, 8'd3, 1, 1'b1, "k11_poke");

      // Abort by reset while an ADD request is outstanding
      L_cyc = 3;
      unit_en = 1'b1;
      @(negedge clk);
      start = 1'b1; k = 4'd11; X_in = 8'd1; Y_in = 8'd2; Z_in = 8'd3;
      @(negedge clk);
      start = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         if (op_req === 1'b1 && op_sel === 1'b1) found = 1'b1;
      end
      check("abort_add_reached", 32'(found), 32'd1);
      unit_en = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      #1;
      check("abort_op_req", 32'(op_req), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_X", 32'(X_out), 32'd1);
      check("abort_Y", 32'(Y_out), 32'd0);
      check("abort_Z", 32'(Z_out), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1 stray = 1'b1;
      @(posedge clk);
      #1 stray = 1'b0;
      bad_done = 1'b0;
      bad_req  = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (done !== 1'b0) bad_done = 1'b1;
         if (op_req !== 1'b0 || busy !== 1'b0) bad_req = 1'b1;
      end
      check("late_ack_no_done", 32'(bad_done), 32'd0);
      check("late_ack_no_req", 32'(bad_req), 32'd0);
      check("late_ack_X", 32'(X_out), 32'd1);

      do_run(4'd3, 8'd1, 8'd4, 8'd6, 0, 1'b0, "k3_after_rst");

      for (int t = 0; t < 10; t++) begin
         do_run(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 8'($urandom),
                int'($urandom_range(0, 3)), 1'b0, "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
